// File: rtl/poets_cpu_debug_pkg.sv
// Shared types and constants for the Nios II debug-monitor memory controller.
// Holds the controller state encoding and the jdo payload field layout.
package poets_cpu_debug_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRdReq  = 2'd1,
    StRdWait = 2'd2,
    StWrReq  = 2'd3
  } mon_state_e;

  localparam int unsigned JDO_RD_BIT    = 35;
  localparam int unsigned JDO_CLR_BIT   = 37;
  localparam int unsigned JDO_ADDR_LSB  = 8;
  localparam int unsigned JDO_WDATA_MSB = 34;
  localparam int unsigned JDO_WDATA_LSB = 3;

  localparam logic [31:0] MON_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/poets_cpu_debug_mon_ctrl.sv
// Debug-monitor memory controller: turns take_* debug strobes into Avalon-MM
// word reads/writes, with a per-transaction timeout and sticky error flag.
module poets_cpu_debug_mon_ctrl
  import poets_cpu_debug_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  // The abort fires on the TIMEOUT-th busy edge, i.e. when the count already holds TIMEOUT-1.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  mon_state_e        state_q, state_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic              rd_mode_q, rd_mode_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       mon_d_reg_q, mon_d_reg_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [31:0]       wdata_q, wdata_d;

  logic any_take;
  logic done;
  logic unused_jdo;

  assign any_take   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign unused_jdo = ^{jdo[36], jdo[2:0]};

  always_comb begin
    state_d     = state_q;
    mon_a_d     = mon_a_q;
    rd_mode_d   = rd_mode_q;
    cnt_d       = cnt_q;
    mon_d_reg_d = mon_d_reg_q;
    error_d     = error_q;
    read_d      = read_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    done        = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (take_action_ocimem_a) begin
          mon_a_d   = jdo[JDO_ADDR_LSB +: ADDR_W];
          rd_mode_d = jdo[JDO_RD_BIT];
          if (jdo[JDO_CLR_BIT]) begin
            error_d = 1'b0;
          end
          if (jdo[JDO_RD_BIT]) begin
            state_d = StRdReq;
            read_d  = 1'b1;
          end
        end else if (take_no_action_ocimem_a) begin
          if (rd_mode_q) begin
            mon_a_d = mon_a_q + ADDR_W'(1);
            state_d = StRdReq;
            read_d  = 1'b1;
          end
        end else if (take_action_ocimem_b) begin
          wdata_d = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
          state_d = StWrReq;
          write_d = 1'b1;
        end
      end

      StRdReq: begin
        if (!avm_waitrequest) begin
          read_d = 1'b0;
          // Zero-latency slave: data arrives with the acceptance edge.
          if (avm_readdatavalid) begin
            mon_d_reg_d = avm_readdata;
            state_d     = StIdle;
            done        = 1'b1;
          end else begin
            state_d = StRdWait;
          end
        end
      end

      StRdWait: begin
        if (avm_readdatavalid) begin
          mon_d_reg_d = avm_readdata;
          state_d     = StIdle;
          done        = 1'b1;
        end
      end

      StWrReq: begin
        if (!avm_waitrequest) begin
          write_d = 1'b0;
          mon_a_d = mon_a_q + ADDR_W'(1);
          state_d = StIdle;
          done    = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase

    if (state_q != StIdle) begin
      if (any_take) begin
        error_d = 1'b1;
      end
      // A completion on the last allowed edge still wins over the abort.
      if (!done && (cnt_q == CntLast)) begin
        read_d      = 1'b0;
        write_d     = 1'b0;
        error_d     = 1'b1;
        mon_d_reg_d = MON_TIMEOUT_DATA;
        mon_a_d     = mon_a_q;
        state_d     = StIdle;
      end else if (!done) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end

    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      mon_a_q     <= '0;
      rd_mode_q   <= 1'b0;
      cnt_q       <= '0;
      mon_d_reg_q <= '0;
      ready_q     <= 1'b1;
      error_q     <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      mon_a_q     <= mon_a_d;
      rd_mode_q   <= rd_mode_d;
      cnt_q       <= cnt_d;
      mon_d_reg_q <= mon_d_reg_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
      read_q      <= read_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
    end
  end

  assign MonDReg       = mon_d_reg_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;
  assign avm_address   = mon_a_q;
  assign avm_read      = read_q;
  assign avm_write     = write_q;
  assign avm_writedata = wdata_q;

endmodule
